// File: rtl/pid_pkg.sv
// Constants shared between the PID controller and its actuator-side consumers.
package pid_pkg;
  localparam int unsigned PID_W      = 15;
  localparam int unsigned PWM_CNT_W  = 10;
  localparam int unsigned PWM_PERIOD = 1000;
  localparam int unsigned PWM_SHIFT  = 5;
  localparam int unsigned PWM_DEAD   = 0;
endpackage

// File: rtl/pid_pwm_out_if.sv
// Valid/ready channel that carries the signed control word from the PID controller.
interface pid_pwm_out_if
  import pid_pkg::*;
#(
  parameter int unsigned W = PID_W
);
  logic signed [W:0] u_in;
  logic              u_valid;
  logic              u_ready;

  modport master (output u_in, output u_valid, input  u_ready);
  modport slave  (input  u_in, input  u_valid, output u_ready);
endinterface

// File: rtl/pid_pwm_out_duty_conv.sv
// Combinational control-word to duty conversion: abs, shift, saturate, deadband.
module pid_duty_conv
  import pid_pkg::*;
#(
  parameter int unsigned W      = PID_W,
  parameter int unsigned CNT_W  = PWM_CNT_W,
  parameter int unsigned PERIOD = PWM_PERIOD,
  parameter int unsigned SHIFT  = PWM_SHIFT,
  parameter int unsigned DEAD   = PWM_DEAD
) (
  input  logic signed [W:0]     u_in,
  output logic        [CNT_W:0] duty,
  output logic                  dir,
  output logic                  sat
);

  logic [W:0]     mag;
  logic [W:0]     shifted;
  logic [31:0]    wide;
  logic [CNT_W:0] duty_sat;

  // Magnitude is taken as unsigned W+1 bits so the most negative word maps to 2^W.
  always_comb begin
    mag      = u_in[W] ? $unsigned(-u_in) : $unsigned(u_in);
    shifted  = mag >> SHIFT;
    wide     = 32'(shifted);
    sat      = 1'b0;
    duty_sat = (CNT_W+1)'(wide);
    if (wide > PERIOD) begin
      duty_sat = (CNT_W+1)'(PERIOD);
      sat      = 1'b1;
    end
    dir = u_in[W];
  end

  generate
    if (DEAD > 0) begin : g_dead
      assign duty = (32'(duty_sat) < DEAD) ? '0 : duty_sat;
    end else begin : g_nodead
      assign duty = duty_sat;
    end
  endgenerate

endmodule

// File: rtl/pid_pwm_out.sv
// Fixed-period PWM actuator driver with period-aligned double-buffered duty and sample strobe.
module pid_pwm_out
  import pid_pkg::*;
#(
  parameter int unsigned W      = PID_W,
  parameter int unsigned CNT_W  = PWM_CNT_W,
  parameter int unsigned PERIOD = PWM_PERIOD,
  parameter int unsigned SHIFT  = PWM_SHIFT,
  parameter int unsigned DEAD   = PWM_DEAD
) (
  input  logic          clk,
  input  logic          reset,
  pid_pwm_out_if.slave  u,
  output logic          pwm_out,
  output logic          dir_out,
  output logic          sat_flag,
  output logic          sample_tick
);

  logic [CNT_W-1:0] cnt;
  logic             wrap;
  logic             accept;

  logic [CNT_W:0]   conv_duty;
  logic             conv_dir;
  logic             conv_sat;

  logic [CNT_W:0]   pend_duty;
  logic             pend_dir;
  logic             pend_sat;
  logic             pend_valid;

  logic [CNT_W:0]   duty_act;

  pid_duty_conv #(
    .W      (W),
    .CNT_W  (CNT_W),
    .PERIOD (PERIOD),
    .SHIFT  (SHIFT),
    .DEAD   (DEAD)
  ) u_conv (
    .u_in (u.u_in),
    .duty (conv_duty),
    .dir  (conv_dir),
    .sat  (conv_sat)
  );

  assign wrap      = (cnt == CNT_W'(PERIOD - 1));
  assign u.u_ready = !pend_valid;
  assign accept    = u.u_valid && !pend_valid;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      cnt <= '0;
    end else if (wrap) begin
      cnt <= '0;
    end else begin
      cnt <= cnt + CNT_W'(1);
    end
  end

  // Accept cannot coincide with a pending transfer since ready is low while pending.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      pend_duty  <= '0;
      pend_dir   <= 1'b0;
      pend_sat   <= 1'b0;
      pend_valid <= 1'b0;
    end else if (wrap && pend_valid) begin
      pend_valid <= 1'b0;
    end else if (accept) begin
      pend_duty  <= conv_duty;
      pend_dir   <= conv_dir;
      pend_sat   <= conv_sat;
      pend_valid <= 1'b1;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      duty_act <= '0;
      dir_out  <= 1'b0;
      sat_flag <= 1'b0;
    end else if (wrap && pend_valid) begin
      duty_act <= pend_duty;
      dir_out  <= pend_dir;
      sat_flag <= pend_sat;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      pwm_out     <= 1'b0;
      sample_tick <= 1'b0;
    end else begin
      pwm_out     <= ({1'b0, cnt} < duty_act);
      sample_tick <= wrap;
    end
  end

endmodule

// File: tb/tb_pid_pwm_out.sv
// Directed bench for pid_pwm_out at default parameters (PERIOD 1000, SHIFT 5).
module tb_pid_pwm_out;

  logic clk = 1'b0;
  logic reset;
  logic pwm_out;
  logic dir_out;
  logic sat_flag;
  logic sample_tick;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  pid_pwm_out_if #(.W(15)) uif ();

  pid_pwm_out #(
    .W      (15),
    .CNT_W  (10),
    .PERIOD (1000),
    .SHIFT  (5),
    .DEAD   (0)
  ) dut (
    .clk         (clk),
    .reset       (reset),
    .u           (uif),
    .pwm_out     (pwm_out),
    .dir_out     (dir_out),
    .sat_flag    (sat_flag),
    .sample_tick (sample_tick)
  );

  // Aligns to a sample_tick cycle (the current one if already high), then
  // observes the 1000 following cycles: one full period of pwm_out.
  task automatic measure(output int high, output int rises, output int ticks);
    int   n;
    logic prev;
    n = 0;
    while (!sample_tick && n < 1100) begin
      @(negedge clk);
      n++;
    end
    checks++;
    if (sample_tick !== 1'b1) begin
      errors++;
      $display("FAIL tick_timeout: sample_tick=%b after %0d clocks, want 1", sample_tick, n);
    end
    high  = 0;
    rises = 0;
    ticks = 0;
    prev  = pwm_out;
    for (int i = 0; i < 1000; i++) begin
      @(negedge clk);
      if (pwm_out === 1'b1) high++;
      if (pwm_out === 1'b1 && prev !== 1'b1) rises++;
      if (sample_tick === 1'b1) ticks++;
      prev = pwm_out;
    end
  endtask

  task automatic send(input logic signed [15:0] v);
    int n;
    n = 0;
    uif.u_in    = v;
    uif.u_valid = 1'b1;
    while (!uif.u_ready && n < 2100) begin
      @(negedge clk);
      n++;
    end
    checks++;
    if (uif.u_ready !== 1'b1) begin
      errors++;
      $display("FAIL send_timeout: u_ready=%b after %0d clocks, want 1", uif.u_ready, n);
    end
    @(negedge clk);
    uif.u_valid = 1'b0;
  endtask

  task automatic test_reset();
    int n, h, r, t;
    reset       = 1'b0;
    uif.u_in    = '0;
    uif.u_valid = 1'b0;
    repeat (5) @(negedge clk);
    checks++;
    if ({pwm_out, dir_out, sat_flag, sample_tick} !== 4'b0000) begin
      errors++;
      $display("FAIL reset_outputs: got %b, want 0000", {pwm_out, dir_out, sat_flag, sample_tick});
    end
    checks++;
    if (uif.u_ready !== 1'b1) begin
      errors++;
      $display("FAIL reset_ready: u_ready=%b, want 1", uif.u_ready);
    end
    reset = 1'b1;
    n = 0;
    while (!sample_tick && n < 1100) begin
      @(negedge clk);
      n++;
    end
    checks++;
    if (n < 999 || n > 1001) begin
      errors++;
      $display("FAIL first_tick: arrived after %0d clocks, want about 1000", n);
    end
    measure(h, r, t);
    checks++;
    if (t !== 1) begin
      errors++;
      $display("FAIL tick_period: %0d ticks in 1000 clocks, want 1", t);
    end
    checks++;
    if (h !== 0) begin
      errors++;
      $display("FAIL idle_duty: high=%0d, want 0", h);
    end
  endtask

  task automatic test_positive();
    int h, r, t;
    send(16'sd3200);
    checks++;
    if (uif.u_ready !== 1'b0) begin
      errors++;
      $display("FAIL pos_ready_drop: u_ready=%b, want 0", uif.u_ready);
    end
    measure(h, r, t);
    checks++;
    if (h !== 100 || r !== 1) begin
      errors++;
      $display("FAIL pos_duty: high=%0d runs=%0d, want 100 and 1", h, r);
    end
    checks++;
    if ({dir_out, sat_flag, uif.u_ready} !== 3'b001) begin
      errors++;
      $display("FAIL pos_flags: dir/sat/ready=%b, want 001", {dir_out, sat_flag, uif.u_ready});
    end
  endtask

  task automatic test_negative_sat();
    logic signed [15:0] vals [3] = '{-16'sd6400, 16'sd32767, -16'sd32768};
    int                 exp_h[3] = '{200, 1000, 1000};
    logic [1:0]         exp_f[3] = '{2'b10, 2'b01, 2'b11};
    int h, r, t;
    for (int i = 0; i < 3; i++) begin
      send(vals[i]);
      measure(h, r, t);
      checks++;
      if (h !== exp_h[i]) begin
        errors++;
        $display("FAIL negsat_duty[%0d]: high=%0d, want %0d", i, h, exp_h[i]);
      end
      checks++;
      if ({dir_out, sat_flag} !== exp_f[i]) begin
        errors++;
        $display("FAIL negsat_flags[%0d]: dir/sat=%b, want %b", i, {dir_out, sat_flag}, exp_f[i]);
      end
    end
  endtask

  task automatic test_back_to_back();
    int stall, high, h, r, t;
    uif.u_in    = 16'sd9600;
    uif.u_valid = 1'b1;
    @(negedge clk);
    checks++;
    if (uif.u_ready !== 1'b0) begin
      errors++;
      $display("FAIL b2b_first_accept: u_ready=%b, want 0", uif.u_ready);
    end
    uif.u_in = -16'sd1600;
    stall = 0;
    while (!uif.u_ready && stall < 1100) begin
      @(negedge clk);
      stall++;
    end
    checks++;
    if (stall !== 999 || sample_tick !== 1'b1) begin
      errors++;
      $display("FAIL b2b_stall: stalled %0d clocks tick=%b, want 999 and 1", stall, sample_tick);
    end
    high = 0;
    for (int i = 0; i < 1000; i++) begin
      @(negedge clk);
      if (i == 0) begin
        uif.u_valid = 1'b0;
        checks++;
        if ({uif.u_ready, dir_out, sat_flag} !== 3'b000) begin
          errors++;
          $display("FAIL b2b_second_accept: ready/dir/sat=%b, want 000", {uif.u_ready, dir_out, sat_flag});
        end
      end
      if (pwm_out === 1'b1) high++;
    end
    checks++;
    if (high !== 300) begin
      errors++;
      $display("FAIL b2b_first_duty: high=%0d, want 300", high);
    end
    for (int k = 0; k < 2; k++) begin
      measure(h, r, t);
      checks++;
      if (h !== 50 || dir_out !== 1'b1 || uif.u_ready !== 1'b1) begin
        errors++;
        $display("FAIL b2b_second_duty[%0d]: high=%0d dir=%b ready=%b, want 50 1 1", k, h, dir_out, uif.u_ready);
      end
    end
  endtask

  task automatic test_wrap_collision();
    int h, r, t;
    repeat (999) @(negedge clk);
    uif.u_in    = 16'sd16000;
    uif.u_valid = 1'b1;
    @(negedge clk);
    uif.u_valid = 1'b0;
    checks++;
    if ({uif.u_ready, sample_tick, dir_out} !== 3'b011) begin
      errors++;
      $display("FAIL wrap_accept: ready/tick/dir=%b, want 011", {uif.u_ready, sample_tick, dir_out});
    end
    measure(h, r, t);
    checks++;
    if (h !== 50) begin
      errors++;
      $display("FAIL wrap_not_applied: high=%0d, want 50", h);
    end
    for (int k = 0; k < 4; k++) begin
      measure(h, r, t);
      checks++;
      if (h !== 500 || dir_out !== 1'b0 || uif.u_ready !== 1'b1) begin
        errors++;
        $display("FAIL wrap_hold[%0d]: high=%0d dir=%b ready=%b, want 500 0 1", k, h, dir_out, uif.u_ready);
      end
    end
  endtask

  task automatic test_reset_mid();
    int h, r, t;
    send(16'sd9600);
    measure(h, r, t);
    checks++;
    if (h !== 300) begin
      errors++;
      $display("FAIL mid_setup_duty: high=%0d, want 300", h);
    end
    send(-16'sd16000);
    repeat (149) @(negedge clk);
    checks++;
    if ({pwm_out, uif.u_ready} !== 2'b10) begin
      errors++;
      $display("FAIL mid_before: pwm/ready=%b, want 10", {pwm_out, uif.u_ready});
    end
    #1 reset = 1'b0;
    #1;
    checks++;
    if ({pwm_out, dir_out, sat_flag, sample_tick, uif.u_ready} !== 5'b00001) begin
      errors++;
      $display("FAIL mid_async: pwm/dir/sat/tick/ready=%b, want 00001",
               {pwm_out, dir_out, sat_flag, sample_tick, uif.u_ready});
    end
    repeat (3) @(negedge clk);
    reset = 1'b1;
    measure(h, r, t);
    checks++;
    if (h !== 0 || dir_out !== 1'b0 || sat_flag !== 1'b0 || uif.u_ready !== 1'b1) begin
      errors++;
      $display("FAIL mid_after: high=%0d dir=%b sat=%b ready=%b, want 0 0 0 1", h, dir_out, sat_flag, uif.u_ready);
    end
  endtask

  initial begin
    test_reset();
    test_positive();
    test_negative_sat();
    test_back_to_back();
    test_wrap_collision();
    test_reset_mid();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
